// File: rtl/mem_array_rf_pkg.sv
// mem_array_rf_pkg
//   Shared types and constants for the word-addressed storage array:
//   - clr_state_t : bulk-clear sequencer state (IDLE, CLEAR)
//   - DEF_DATA_W  : default word width
//   - addr_w_for  : address width needed to reach every word of a given depth
package mem_array_rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 8;

  // Parents use this to size ADDR_W from DEPTH; a depth of 2 still needs one bit.
  function automatic int unsigned addr_w_for(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// mem_clear_seq
//   Bulk-clear sequencer: on clr_req in IDLE it walks every word address
//   0..DEPTH-1, one per cycle, then returns to IDLE. A clear takes exactly
//   DEPTH cycles and cannot be restarted or extended while running.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr_req  in   start request (pulse or level), sampled only in IDLE
//   clr_busy out  registered, high for the whole clear
//   clr_addr out  word currently being cleared
//   clr_we   out  clear write strobe for clr_addr
module mem_clear_seq
  import mem_array_rf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  // Terminal count is DEPTH-1, not all-ones, so non-power-of-two depths work.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_addr = cnt;
  assign clr_we   = (state == CLEAR);

endmodule

// File: rtl/mem_array_rf.sv
// mem_array_rf
//   Clocked array of DEPTH words x DATA_W bits with a registered read port
//   (write-first on same-cycle read/write), address range checking and a
//   sequenced bulk-clear engine (mem_clear_seq).
// Ports:
//   clk        in   system clock, all updates on rising edge
//   rst_n      in   asynchronous active-low reset
//   addr       in   word address shared by read and write
//   din        in   write data
//   st         in   store strobe
//   mw         in   memory-write request
//   wr         in   register-write request
//   rd         in   read request
//   clr_req    in   start bulk clear
//   dout       out  registered read data (holds when no valid read)
//   dout_valid out  dout carries the previous cycle's read
//   clr_busy   out  clear engine active
//   err        out  one-cycle pulse for a rejected access
module mem_array_rf
  import mem_array_rf_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              st,
  input  logic              mw,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr_req,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              clr_busy,
  output logic              err
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle;
  logic              in_range;
  logic              wr_strobe;
  logic              we_user;
  logic              rd_ok;
  logic              reject;

  mem_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  always_comb begin
    idle      = !clr_busy;
    in_range  = ({1'b0, addr} < DEPTH_V);
    wr_strobe = (mw | wr) & st;
    we_user   = wr_strobe & in_range & idle;
    rd_ok     = rd & in_range & idle;
    // Any attempted access that cannot be serviced, either out of range or
    // while the clear engine owns the array.
    reject    = (rd | wr_strobe) & !(in_range & idle);
  end

  // Storage. The clear engine and user writes are mutually exclusive in time
  // (user writes need IDLE), so the clear path simply takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= RESET_VAL;
    end else if (we_user) begin
      mem[addr] <= din;
    end
  end

  // Read and write share addr, so a concurrent write is always to the
  // read address: forward din to get write-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= reject;
      if (rd_ok) begin
        dout       <= we_user ? din : mem[addr];
        dout_valid <= 1'b1;
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_array_rf.sv
// tb_mem_array_rf
//   Directed bench for mem_array_rf: a DEPTH=16 instance for the main
//   function and clear engine, and a DEPTH=12 instance for range checks.
module tb_mem_array_rf;
  import mem_array_rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [3:0] addr;
  logic [7:0] din;
  logic       st, mw, wr, rd, clr_req;
  logic [7:0] dout;
  logic       dout_valid, clr_busy, err;

  logic [3:0] b_addr;
  logic [7:0] b_din;
  logic       b_st, b_mw, b_wr, b_rd, b_clr_req;
  logic [7:0] b_dout;
  logic       b_dout_valid, b_clr_busy, b_err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_array_rf #(
    .DATA_W    (DEF_DATA_W),
    .DEPTH     (16),
    .ADDR_W    (4),
    .RESET_VAL (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .din        (din),
    .st         (st),
    .mw         (mw),
    .wr         (wr),
    .rd         (rd),
    .clr_req    (clr_req),
    .dout       (dout),
    .dout_valid (dout_valid),
    .clr_busy   (clr_busy),
    .err        (err)
  );

  mem_array_rf #(
    .DATA_W    (DEF_DATA_W),
    .DEPTH     (12),
    .ADDR_W    (4),
    .RESET_VAL (8'h00)
  ) dut12 (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (b_addr),
    .din        (b_din),
    .st         (b_st),
    .mw         (b_mw),
    .wr         (b_wr),
    .rd         (b_rd),
    .clr_req    (b_clr_req),
    .dout       (b_dout),
    .dout_valid (b_dout_valid),
    .clr_busy   (b_clr_busy),
    .err        (b_err)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st = 1'b0; mw = 1'b0; wr = 1'b0; rd = 1'b0; clr_req = 1'b0;
    b_st = 1'b0; b_mw = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic use_wr);
    addr = a; din = d; st = 1'b1; mw = !use_wr; wr = use_wr;
    step();
    st = 1'b0; mw = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    addr = a; rd = 1'b1;
    step();
    rd = 1'b0;
    check_vec($sformatf("%s_valid[%0d]", tag, a), {31'd0, dout_valid}, 32'd1);
    check_vec($sformatf("%s_data[%0d]", tag, a), {24'd0, dout}, {24'd0, exp});
  endtask

  task automatic b_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    b_addr = a; b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    check_vec($sformatf("%s_valid[%0d]", tag, a), {31'd0, b_dout_valid}, 32'd1);
    check_vec($sformatf("%s_data[%0d]", tag, a), {24'd0, b_dout}, {24'd0, exp});
  endtask

  initial begin
    int n;
    addr = '0; din = '0; b_addr = '0; b_din = '0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    repeat (2) step();
    check_vec("rst_dout",     {24'd0, dout},     32'h00);
    check_vec("rst_valid",    {31'd0, dout_valid}, 32'd0);
    check_vec("rst_busy",     {31'd0, clr_busy}, 32'd0);
    check_vec("rst_err",      {31'd0, err},      32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) do_read(4'(i), 8'h00, "rst_scan");

    // Basic writes through mw and wr, and a gated write without st
    do_write(4'd3, 8'hA5, 1'b0);
    do_read(4'd3, 8'hA5, "mw_wr");
    do_write(4'd7, 8'h3C, 1'b1);
    do_read(4'd7, 8'h3C, "wr_wr");
    addr = 4'd3; din = 8'h11; mw = 1'b1; st = 1'b0;
    step();
    mw = 1'b0;
    do_read(4'd3, 8'hA5, "no_st");

    // Write-first on same-cycle read/write
    addr = 4'd5; din = 8'h5A; st = 1'b1; mw = 1'b1; rd = 1'b1;
    step();
    st = 1'b0; mw = 1'b0; rd = 1'b0;
    check_vec("wf_valid", {31'd0, dout_valid}, 32'd1);
    check_vec("wf_data",  {24'd0, dout},       32'h5A);
    do_read(4'd5, 8'h5A, "wf_later");

    // Range checks on the DEPTH=12 instance
    b_addr = 4'd13; b_din = 8'h77; b_st = 1'b1; b_mw = 1'b1;
    step();
    b_st = 1'b0; b_mw = 1'b0;
    check_vec("oor_wr_err",   {31'd0, b_err},        32'd1);
    check_vec("oor_wr_valid", {31'd0, b_dout_valid}, 32'd0);
    step();
    check_vec("oor_err_pulse", {31'd0, b_err}, 32'd0);
    b_addr = 4'd13; b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    check_vec("oor_rd_err",   {31'd0, b_err},        32'd1);
    check_vec("oor_rd_valid", {31'd0, b_dout_valid}, 32'd0);
    b_addr = 4'd12; b_din = 8'h66; b_st = 1'b1; b_wr = 1'b1;
    step();
    b_st = 1'b0; b_wr = 1'b0;
    check_vec("oor12_err", {31'd0, b_err}, 32'd1);
    b_addr = 4'd11; b_din = 8'h4B; b_st = 1'b1; b_mw = 1'b1;
    step();
    b_st = 1'b0; b_mw = 1'b0;
    check_vec("last_ok_err", {31'd0, b_err}, 32'd0);
    for (int i = 0; i < 11; i++) b_read(4'(i), 8'h00, "oor_scan");
    b_read(4'd11, 8'h4B, "oor_scan");

    // Bulk clear
    for (int i = 0; i < 16; i++) do_write(4'(i), 8'hFF, 1'b0);
    do_read(4'd9, 8'hFF, "fill");
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 0;
    for (int g = 0; g < 40; g++) begin
      if (!clr_busy) break;
      n++;
      if (n == 4) begin addr = 4'd2; rd = 1'b1; end
      if (n == 5) begin
        rd = 1'b0;
        check_vec("clr_rd_err",   {31'd0, err},        32'd1);
        check_vec("clr_rd_valid", {31'd0, dout_valid}, 32'd0);
      end
      if (n == 8) clr_req = 1'b1;
      if (n == 9) clr_req = 1'b0;
      step();
    end
    check_vec("clr_cycles", n, 32'd16);
    check_vec("clr_done_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 16; i++) do_read(4'(i), 8'h00, "clr_scan");

    // Reset during a clear
    for (int i = 9; i < 16; i++) do_write(4'(i), 8'hFF, 1'b1);
    do_read(4'd15, 8'hFF, "pre_abort");
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (5) step();
    check_vec("abort_busy_before", {31'd0, clr_busy}, 32'd1);
    check_vec("abort_dout_before", {24'd0, dout},     32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check_vec("abort_busy",  {31'd0, clr_busy},   32'd0);
    check_vec("abort_dout",  {24'd0, dout},       32'h00);
    check_vec("abort_valid", {31'd0, dout_valid}, 32'd0);
    check_vec("abort_err",   {31'd0, err},        32'd0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) do_read(4'(i), 8'h00, "abort_scan");
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check_vec("reclr_busy", {31'd0, clr_busy}, 32'd1);
    n = 0;
    for (int g = 0; g < 40; g++) begin
      if (!clr_busy) break;
      n++;
      step();
    end
    check_vec("reclr_cycles", n, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
